// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and widths for the pipeline hazard/stall controller
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W  = 4;
  localparam int STALL_CNT_W = 16;

  // RUN: normal issue; MEM_WAIT: pipeline frozen behind an outstanding data access
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - source/destination hazard compare; rule selected by PIPE_CTRL_FORWARDING_EN
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

  logic ex_match1;
  logic ex_match2;
  logic hz1;
  logic hz2;

  assign ex_match1 = ex_wb_en && (ex_dest == id_src1);
  assign ex_match2 = ex_wb_en && (ex_dest == id_src2);

`ifdef PIPE_CTRL_FORWARDING_EN
  // Forwarding covers everything except a load result still in EX.
  logic unused_mem_fwd;
  assign unused_mem_fwd = ^{mem_dest, mem_wb_en};

  assign hz1 = id_use_src1 && ex_match1 && ex_mem_r_en;
  assign hz2 = id_use_src2 && ex_match2 && ex_mem_r_en;
`else
  // No bypass paths: any in-flight writer of a source register blocks issue.
  logic mem_match1;
  logic mem_match2;
  logic unused_load_flag;
  assign unused_load_flag = ex_mem_r_en;

  assign mem_match1 = mem_wb_en && (mem_dest == id_src1);
  assign mem_match2 = mem_wb_en && (mem_dest == id_src2);

  assign hz1 = id_use_src1 && (ex_match1 || mem_match1);
  assign hz2 = id_use_src2 && (ex_match2 || mem_match2);
`endif

  assign hazard = hz1 || hz2;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with memory-wait FSM; optional PIPE_CTRL_FORWARDING_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_use_src1,
  input  logic                   id_use_src2,
  input  logic [REG_ADDR_W-1:0]  ex_dest,
  input  logic                   ex_wb_en,
  input  logic                   ex_mem_r_en,
  input  logic [REG_ADDR_W-1:0]  mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en_o,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_t state;
  logic   hazard;
  logic   freeze;

  hazard_detect u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src1 (id_use_src1),
    .id_use_src2 (id_use_src2),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_r_en (ex_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .hazard      (hazard)
  );

  assign freeze = ((state == RUN) && mem_req && !mem_ready) ||
                  ((state == MEM_WAIT) && !mem_ready);

  // Track whether a data access is still outstanding; leave the wait the cycle it completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (freeze) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Zero-latency enable/flush decode: reset, then freeze, then branch, then hazard.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en_o = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst || freeze) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Count cycles the PC is held, saturating so long runs never alias to small values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
